// File: rtl/anahtar_genisletme.sv
// anahtar_genisletme: sequential AES-128 key expansion feeding a single-round
// encryption datapath. Presents round keys 0..10 one at a time over valid/ready.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   anahtar      128-bit cipher key, byte 0 in [127:120], sampled on accepted start
//   baslat       start pulse, honoured only in BOS
//   ters         (ANAHTAR_TERS_EN only) reverse-order request, sampled with baslat
//   hazir        consumer ready
//   tur_anahtari current round key, same byte order as anahtar
//   tur_no       round index of tur_anahtari, 0..10
//   gecerli      tur_anahtari/tur_no valid
//   mesgul       high whenever the FSM is not in BOS
//   bitti        one-cycle pulse after the last key is accepted
//
// Optional feature, macro ANAHTAR_TERS_EN: adds the ters input, an 11 x 128
// round-key buffer and the DOLDUR state, so keys can be presented 10 down to 0.

// Bit_Degisikligi: SubWord, four parallel AES S-box lookups on a 32-bit word.
module Bit_Degisikligi (
  input  logic [31:0] giris_i,
  output logic [31:0] cikis_o
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // One lookup per byte lane.
  for (genvar g = 0; g < 4; g++) begin : g_bayt
    assign cikis_o[8*g +: 8] = SBOX[giris_i[8*g +: 8]];
  end

endmodule

module anahtar_genisletme (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] anahtar,
  input  logic         baslat,
`ifdef ANAHTAR_TERS_EN
  input  logic         ters,
`endif
  input  logic         hazir,
  output logic [127:0] tur_anahtari,
  output logic [3:0]   tur_no,
  output logic         gecerli,
  output logic         mesgul,
  output logic         bitti
);

  localparam int unsigned KW   = 128;
  localparam int unsigned NW   = 4;
  localparam int unsigned NTUR = 11;
  localparam logic [NW-1:0] SON_TUR = NW'(NTUR - 1);

  // Round constants indexed by the round being produced; unused slots are 0.
  localparam logic [7:0] RCON [16] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

`ifdef ANAHTAR_TERS_EN
  typedef enum logic [1:0] {BOS = 2'd0, URET = 2'd1, DOLDUR = 2'd2} durum_e;
`else
  typedef enum logic [0:0] {BOS = 1'b0, URET = 1'b1} durum_e;
`endif

  durum_e          durum_q, durum_d;
  logic [KW-1:0]   tur_anahtari_q, tur_anahtari_d;
  logic [NW-1:0]   tur_no_q, tur_no_d;
  logic            gecerli_q, gecerli_d;
  logic            mesgul_q, mesgul_d;
  logic            bitti_q, bitti_d;

  // Next round key from the current one.
  logic [31:0]     w0, w1, w2, w3;
  logic [31:0]     sub_w, t_w, n0, n1, n2, n3;
  logic [NW-1:0]   rc_idx;
  logic [KW-1:0]   sonraki;

  assign {w0, w1, w2, w3} = tur_anahtari_q;
  assign rc_idx           = tur_no_q + NW'(1);

  Bit_Degisikligi u_bit_degisikligi (
    .giris_i ({w3[23:0], w3[31:24]}),
    .cikis_o (sub_w)
  );

  assign t_w     = sub_w ^ {RCON[rc_idx], 24'h0};
  assign n0      = w0 ^ t_w;
  assign n1      = w1 ^ n0;
  assign n2      = w2 ^ n1;
  assign n3      = w3 ^ n2;
  assign sonraki = {n0, n1, n2, n3};

`ifdef ANAHTAR_TERS_EN
  logic [KW-1:0]   tampon_q [NTUR];
  logic            tampon_we;
  logic [NW-1:0]   tampon_adr;
  logic [KW-1:0]   tampon_veri;
  logic            ters_q, ters_d;

  // Round-key buffer, written as each key is produced.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NTUR; i++) tampon_q[i] <= '0;
    end else if (tampon_we) begin
      tampon_q[tampon_adr] <= tampon_veri;
    end
  end
`endif

  // Next-state and output logic.
  always_comb begin
    durum_d        = durum_q;
    tur_anahtari_d = tur_anahtari_q;
    tur_no_d       = tur_no_q;
    gecerli_d      = gecerli_q;
    bitti_d        = 1'b0;
`ifdef ANAHTAR_TERS_EN
    ters_d         = ters_q;
    tampon_we      = 1'b0;
    tampon_adr     = rc_idx;
    tampon_veri    = sonraki;
`endif

    case (durum_q)
      BOS: begin
        if (baslat) begin
          tur_anahtari_d = anahtar;
          tur_no_d       = '0;
          gecerli_d      = 1'b1;
          durum_d        = URET;
`ifdef ANAHTAR_TERS_EN
          ters_d         = ters;
          tampon_we      = 1'b1;
          tampon_adr     = '0;
          tampon_veri    = anahtar;
          if (ters) begin
            gecerli_d    = 1'b0;
            durum_d      = DOLDUR;
          end
`endif
        end
      end

      URET: begin
        if (gecerli_q && hazir) begin
`ifdef ANAHTAR_TERS_EN
          // Reverse order walks the buffer down to round 0.
          if (ters_q) begin
            if (tur_no_q != '0) begin
              tur_anahtari_d = tampon_q[tur_no_q - NW'(1)];
              tur_no_d       = tur_no_q - NW'(1);
            end else begin
              gecerli_d      = 1'b0;
              bitti_d        = 1'b1;
              durum_d        = BOS;
            end
          end else
`endif
          if (tur_no_q != SON_TUR) begin
            tur_anahtari_d = sonraki;
            tur_no_d       = rc_idx;
`ifdef ANAHTAR_TERS_EN
            tampon_we      = 1'b1;
`endif
          end else begin
            gecerli_d      = 1'b0;
            bitti_d        = 1'b1;
            durum_d        = BOS;
          end
        end
      end

`ifdef ANAHTAR_TERS_EN
      // Precompute all rounds into the buffer, then present round 10 first.
      DOLDUR: begin
        if (tur_no_q != SON_TUR) begin
          tur_anahtari_d = sonraki;
          tur_no_d       = rc_idx;
          tampon_we      = 1'b1;
        end else begin
          gecerli_d      = 1'b1;
          durum_d        = URET;
        end
      end
`endif

      default: durum_d = BOS;
    endcase

    mesgul_d = (durum_d != BOS);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      durum_q        <= BOS;
      tur_anahtari_q <= '0;
      tur_no_q       <= '0;
      gecerli_q      <= 1'b0;
      mesgul_q       <= 1'b0;
      bitti_q        <= 1'b0;
`ifdef ANAHTAR_TERS_EN
      ters_q         <= 1'b0;
`endif
    end else begin
      durum_q        <= durum_d;
      tur_anahtari_q <= tur_anahtari_d;
      tur_no_q       <= tur_no_d;
      gecerli_q      <= gecerli_d;
      mesgul_q       <= mesgul_d;
      bitti_q        <= bitti_d;
`ifdef ANAHTAR_TERS_EN
      ters_q         <= ters_d;
`endif
    end
  end

  assign tur_anahtari = tur_anahtari_q;
  assign tur_no       = tur_no_q;
  assign gecerli      = gecerli_q;
  assign mesgul       = mesgul_q;
  assign bitti        = bitti_q;

endmodule

// File: tb/tb_anahtar_genisletme.sv
// tb_anahtar_genisletme: self-checking bench for anahtar_genisletme. The
// reference builds the S-box from GF(2^8) inversion plus the affine map and
// expands keys with the word-recurrence form of the key schedule.
`timescale 1ns/1ps
module tb_anahtar_genisletme;

  localparam logic [127:0] KEY_A   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] TUR1_A  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] TUR10_A = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam int MAXC = 300;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         baslat = 1'b0;
  logic         hazir = 1'b0;
  logic [127:0] anahtar = '0;
`ifdef ANAHTAR_TERS_EN
  logic         ters = 1'b0;
`endif
  logic [127:0] tur_anahtari;
  logic [3:0]   tur_no;
  logic         gecerli, mesgul, bitti;

  logic [135:0] gozlem, beklenen;
  int           nchk = 0;
  int           nerr = 0;
  logic [7:0]   sbt [256];
  logic [127:0] exp_k [11];

  assign gozlem = {gecerli, mesgul, bitti, 1'b0, tur_no, tur_anahtari};

  anahtar_genisletme dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .anahtar      (anahtar),
    .baslat       (baslat),
`ifdef ANAHTAR_TERS_EN
    .ters         (ters),
`endif
    .hazir        (hazir),
    .tur_anahtari (tur_anahtari),
    .tur_no       (tur_no),
    .gecerli      (gecerli),
    .mesgul       (mesgul),
    .bitti        (bitti)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xtime(x);
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, r, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv;
      r = inv;
      for (int k = 0; k < 4; k++) begin
        r = {r[6:0], r[7]};
        s ^= r;
      end
      sbt[x] = s ^ 8'h63;
    end
  endtask

  task automatic expand(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbt[tmp[31:24]], sbt[tmp[23:16]], sbt[tmp[15:8]], sbt[tmp[7:0]]};
        tmp[31:24] ^= rc;
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++) exp_k[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] rnd_key();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic start(input logic [127:0] k);
    @(negedge clk);
    anahtar = k;
    baslat  = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; baslat = 1'b1; anahtar = KEY_A; hazir = 1'b1;
    @(posedge clk); #1;
    nchk++;
    if (gozlem !== '0) begin nerr++; $display("FAIL reset_low: got %h want 0", gozlem); end
    @(posedge clk); #1;
    nchk++;
    if (gozlem !== '0) begin nerr++; $display("FAIL reset_hold_baslat: got %h want 0", gozlem); end
    @(negedge clk); rst_n = 1'b1; baslat = 1'b0;
    @(negedge clk);
    nchk++;
    if (gozlem !== '0) begin nerr++; $display("FAIL reset_release: got %h want 0", gozlem); end
  endtask

  task automatic test_forward();
    int idx; bit son, bitdi;
    expand(KEY_A); idx = 0; son = 0; bitdi = 0;
    start(KEY_A);
    for (int c = 1; c <= MAXC && !bitdi; c++) begin
      @(negedge clk); baslat = 1'b0; hazir = 1'b1;
      if (son) begin
        nchk++;
        if (gozlem[135:133] !== 3'b001 || c != 12) begin
          nerr++; $display("FAIL fwd_bitti: got flags %b at cycle %0d want 001 at 12", gozlem[135:133], c);
        end
        bitdi = 1;
      end else begin
        beklenen = {3'b110, 1'b0, 4'(idx), exp_k[idx]};
        nchk++;
        if (gozlem !== beklenen) begin nerr++; $display("FAIL fwd_round%0d: got %h want %h", idx, gozlem, beklenen); end
        if (idx == 0) begin nchk++; if (tur_anahtari !== KEY_A) begin nerr++; $display("FAIL fwd_vec0: got %h want %h", tur_anahtari, KEY_A); end end
        if (idx == 1) begin nchk++; if (tur_anahtari !== TUR1_A) begin nerr++; $display("FAIL fwd_vec1: got %h want %h", tur_anahtari, TUR1_A); end end
        if (idx == 10) begin nchk++; if (tur_anahtari !== TUR10_A) begin nerr++; $display("FAIL fwd_vec10: got %h want %h", tur_anahtari, TUR10_A); end end
        if (idx == 10) son = 1; else idx++;
      end
    end
    nchk++;
    if (!bitdi) begin nerr++; $display("FAIL fwd_timeout: got no bitti want bitti within %0d cycles", MAXC); end
    @(negedge clk);
    nchk++;
    if (gozlem[135:133] !== 3'b000) begin nerr++; $display("FAIL fwd_single_pulse: got flags %b want 000", gozlem[135:133]); end
  endtask

  task automatic test_backpressure();
    int idx; bit son, bitdi;
    expand(KEY_A); idx = 0; son = 0; bitdi = 0;
    start(KEY_A);
    for (int c = 1; c <= MAXC && !bitdi; c++) begin
      @(negedge clk); baslat = 1'b0;
      if (son) begin
        nchk++;
        if (gozlem[135:133] !== 3'b001) begin nerr++; $display("FAIL bp_bitti: got flags %b want 001", gozlem[135:133]); end
        bitdi = 1;
      end else begin
        beklenen = {3'b110, 1'b0, 4'(idx), exp_k[idx]};
        nchk++;
        if (gozlem !== beklenen) begin nerr++; $display("FAIL bp_round%0d c=%0d: got %h want %h", idx, c, gozlem, beklenen); end
        hazir = 1'($urandom_range(0, 1));
        if (hazir) begin if (idx == 10) son = 1; else idx++; end
      end
    end
    nchk++;
    if (!bitdi) begin nerr++; $display("FAIL bp_timeout: got no bitti want bitti within %0d cycles", MAXC); end
    @(negedge clk);
    nchk++;
    if (gozlem[135:133] !== 3'b000) begin nerr++; $display("FAIL bp_single_pulse: got flags %b want 000", gozlem[135:133]); end
  endtask

  task automatic test_ignored_start();
    int idx; bit son, bitdi, atildi;
    logic [127:0] ka, kb;
    ka = rnd_key(); kb = rnd_key();
    expand(ka); idx = 0; son = 0; bitdi = 0; atildi = 0;
    start(ka);
    for (int c = 1; c <= MAXC && !bitdi; c++) begin
      @(negedge clk); baslat = 1'b0;
      if (son) begin
        nchk++;
        if (gozlem[135:133] !== 3'b001) begin nerr++; $display("FAIL ign_bitti: got flags %b want 001", gozlem[135:133]); end
        bitdi = 1;
      end else begin
        beklenen = {3'b110, 1'b0, 4'(idx), exp_k[idx]};
        nchk++;
        if (gozlem !== beklenen) begin nerr++; $display("FAIL ign_round%0d: got %h want %h", idx, gozlem, beklenen); end
        if (idx == 5 && !atildi) begin anahtar = kb; baslat = 1'b1; atildi = 1; end
        hazir = 1'($urandom_range(0, 1));
        if (hazir) begin if (idx == 10) son = 1; else idx++; end
      end
    end
    nchk++;
    if (!bitdi) begin nerr++; $display("FAIL ign_timeout: got no bitti want bitti within %0d cycles", MAXC); end
    // A start from BOS must now take the new key.
    expand(kb); idx = 0; son = 0; bitdi = 0;
    start(kb);
    for (int c = 1; c <= MAXC && !bitdi; c++) begin
      @(negedge clk); baslat = 1'b0; hazir = 1'b1;
      if (son) begin
        nchk++;
        if (gozlem[135:133] !== 3'b001) begin nerr++; $display("FAIL ign_new_bitti: got flags %b want 001", gozlem[135:133]); end
        bitdi = 1;
      end else begin
        beklenen = {3'b110, 1'b0, 4'(idx), exp_k[idx]};
        nchk++;
        if (gozlem !== beklenen) begin nerr++; $display("FAIL ign_new_round%0d: got %h want %h", idx, gozlem, beklenen); end
        if (idx == 10) son = 1; else idx++;
      end
    end
    nchk++;
    if (!bitdi) begin nerr++; $display("FAIL ign_new_timeout: got no bitti want bitti within %0d cycles", MAXC); end
  endtask

  task automatic test_async_reset();
    int idx; bit kesildi, bitdi;
    expand(KEY_A); idx = 0; kesildi = 0; bitdi = 0;
    start(KEY_A);
    for (int c = 1; c <= MAXC && !kesildi; c++) begin
      @(negedge clk); baslat = 1'b0; hazir = 1'b1;
      beklenen = {3'b110, 1'b0, 4'(idx), exp_k[idx]};
      nchk++;
      if (gozlem !== beklenen) begin nerr++; $display("FAIL rst_round%0d: got %h want %h", idx, gozlem, beklenen); end
      if (idx == 7) begin
        #2 rst_n = 1'b0;
        #1;
        nchk++;
        if (gozlem !== '0) begin nerr++; $display("FAIL rst_async_clear: got %h want 0", gozlem); end
        kesildi = 1;
      end else idx++;
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); @(negedge clk);
    nchk++;
    if (gozlem !== '0) begin nerr++; $display("FAIL rst_no_resume: got %h want 0", gozlem); end
    start(KEY_A);
    idx = 0;
    for (int c = 1; c <= MAXC && !bitdi; c++) begin
      @(negedge clk); baslat = 1'b0; hazir = 1'b1;
      if (idx == 11) begin
        nchk++;
        if (gozlem[135:133] !== 3'b001) begin nerr++; $display("FAIL rst_restart_bitti: got flags %b want 001", gozlem[135:133]); end
        bitdi = 1;
      end else begin
        beklenen = {3'b110, 1'b0, 4'(idx), exp_k[idx]};
        nchk++;
        if (gozlem !== beklenen) begin nerr++; $display("FAIL rst_restart_round%0d: got %h want %h", idx, gozlem, beklenen); end
        idx++;
      end
    end
    nchk++;
    if (!bitdi) begin nerr++; $display("FAIL rst_restart_timeout: got no bitti want bitti within %0d cycles", MAXC); end
  endtask

  task automatic test_back_to_back();
    int idx; bit son, bitdi;
    logic [127:0] ka, kb;
    ka = rnd_key(); kb = rnd_key();
    expand(ka); idx = 0; son = 0; bitdi = 0;
    start(ka);
    for (int c = 1; c <= MAXC && !bitdi; c++) begin
      @(negedge clk); baslat = 1'b0; hazir = 1'b1;
      if (son) begin
        // Start raised on the bitti edge was dropped; BOS now takes this one.
        nchk++;
        if (gozlem[135:133] !== 3'b001) begin nerr++; $display("FAIL b2b_bitti: got flags %b want 001", gozlem[135:133]); end
        baslat = 1'b1;
        bitdi = 1;
      end else begin
        beklenen = {3'b110, 1'b0, 4'(idx), exp_k[idx]};
        nchk++;
        if (gozlem !== beklenen) begin nerr++; $display("FAIL b2b_round%0d: got %h want %h", idx, gozlem, beklenen); end
        if (idx == 10) begin son = 1; anahtar = kb; baslat = 1'b1; end else idx++;
      end
    end
    expand(kb); idx = 0; son = 0; bitdi = 0;
    for (int c = 1; c <= MAXC && !bitdi; c++) begin
      @(negedge clk); baslat = 1'b0; hazir = 1'b1;
      if (son) begin
        nchk++;
        if (gozlem[135:133] !== 3'b001 || c != 12) begin
          nerr++; $display("FAIL b2b_second_bitti: got flags %b at cycle %0d want 001 at 12", gozlem[135:133], c);
        end
        bitdi = 1;
      end else begin
        beklenen = {3'b110, 1'b0, 4'(idx), exp_k[idx]};
        nchk++;
        if (gozlem !== beklenen) begin nerr++; $display("FAIL b2b_second_round%0d: got %h want %h", idx, gozlem, beklenen); end
        if (idx == 10) son = 1; else idx++;
      end
    end
    nchk++;
    if (!bitdi) begin nerr++; $display("FAIL b2b_timeout: got no bitti want bitti within %0d cycles", MAXC); end
  endtask

`ifdef ANAHTAR_TERS_EN
  task automatic test_reverse();
    int idx; bit son, bitdi;
    expand(KEY_A); idx = 10; son = 0; bitdi = 0;
    @(negedge clk); anahtar = KEY_A; baslat = 1'b1; ters = 1'b1; hazir = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk); baslat = 1'b0; ters = 1'b0;
      nchk++;
      if (gozlem[135:134] !== 2'b01) begin nerr++; $display("FAIL rev_fill c=%0d: got gecerli/mesgul %b want 01", c, gozlem[135:134]); end
    end
    for (int c = 12; c <= MAXC && !bitdi; c++) begin
      @(negedge clk);
      if (son) begin
        nchk++;
        if (gozlem[135:133] !== 3'b001) begin nerr++; $display("FAIL rev_bitti: got flags %b want 001", gozlem[135:133]); end
        bitdi = 1;
      end else begin
        beklenen = {3'b110, 1'b0, 4'(idx), exp_k[idx]};
        nchk++;
        if (gozlem !== beklenen) begin nerr++; $display("FAIL rev_round%0d c=%0d: got %h want %h", idx, c, gozlem, beklenen); end
        if (idx == 10) begin nchk++; if (tur_anahtari !== TUR10_A) begin nerr++; $display("FAIL rev_vec10: got %h want %h", tur_anahtari, TUR10_A); end end
        hazir = 1'($urandom_range(0, 1));
        if (hazir) begin if (idx == 0) son = 1; else idx--; end
      end
    end
    nchk++;
    if (!bitdi) begin nerr++; $display("FAIL rev_timeout: got no bitti want bitti within %0d cycles", MAXC); end
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish want finish before 2ms");
    $fatal(1);
  end

  initial begin
    build_sbox();
    test_reset();
    test_forward();
    test_backpressure();
    test_ignored_start();
    test_async_reset();
    test_back_to_back();
`ifdef ANAHTAR_TERS_EN
    test_reverse();
`endif
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
